// File: rtl/rcu_wrb_pkg.sv
// -----------------------------------------------------------------------------
// rcu_wrb_pkg
//   Shared definitions for the writeback funnel (wrb_port_arbiter).
//   - NUM_WRB_SRC / SRC_IDX_W : number of execution-unit sources and index width
//   - SRC_ALU1/ALU2/LSU/MD    : bit index of each unit in the source vectors
//   - wrb_entry_t             : one buffered writeback {preg address, result}
// -----------------------------------------------------------------------------
package rcu_wrb_pkg;

    localparam int NUM_WRB_SRC = 4;
    localparam int SRC_IDX_W   = 2;

    localparam int SRC_ALU1 = 0;
    localparam int SRC_ALU2 = 1;
    localparam int SRC_LSU  = 2;
    localparam int SRC_MD   = 3;

    localparam int WRB_ADDR_W = 6;
    localparam int WRB_DATA_W = 64;

    typedef struct packed {
        logic [WRB_ADDR_W-1:0] addr;
        logic [WRB_DATA_W-1:0] data;
    } wrb_entry_t;

endpackage

// File: rtl/wrb_src_fifo.sv
// -----------------------------------------------------------------------------
// wrb_src_fifo
//   Small circular-buffer FIFO holding writebacks from one execution unit.
//   DEPTH must be a power of two so the pointers wrap naturally.
// Ports
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write wr_data this cycle (caller guarantees !full)
//   pop        : drop the head this cycle (caller guarantees !empty)
//   wr_data    : entry to write
//   rd_data    : current head entry (valid when !empty)
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module wrb_src_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    // Storage carries no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/wrb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wrb_port_arbiter
//   Writeback funnel: four execution units (alu1, alu2, lsu, md) each push
//   {preg, 64-bit result} into a private FIFO; a round-robin arbiter drains up
//   to two heads per cycle onto two registered regfile write ports.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   src_valid_i[4]  : source beat valid (0=alu1, 1=alu2, 2=lsu, 3=md)
//   src_ready_o[4]  : source FIFO has room
//   src_address_i   : preg of source i at [i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]
//   src_data_i      : result of source i at [i*64 +: 64]
//   wrb0_*          : write port 0 (valid, preg, data), registered
//   wrb1_*          : write port 1 (valid, preg, data), registered
//
// Configuration macro
//   WRB_ZERO_FILTER_EN : beats addressed to preg 0 are handshaked but dropped.
//
// Handshake: a beat moves when src_valid_i[i] && src_ready_o[i] at posedge clk.
// The source keeps address/data stable while valid && !ready. Ready reflects
// FIFO occupancy only (a full FIFO is not ready even if it pops that cycle),
// and is low while rst is high.
// -----------------------------------------------------------------------------
module wrb_port_arbiter
    import rcu_wrb_pkg::*;
#(
    parameter int REG_SIZE       = 48,
    parameter int REG_SIZE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_WRB_SRC-1:0]                src_valid_i,
    output logic [NUM_WRB_SRC-1:0]                src_ready_o,
    input  logic [NUM_WRB_SRC*REG_SIZE_WIDTH-1:0] src_address_i,
    input  logic [NUM_WRB_SRC*64-1:0]             src_data_i,
    output logic                                  wrb0_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]             wrb0_address_o,
    output logic [63:0]                           wrb0_data_o,
    output logic                                  wrb1_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]             wrb1_address_o,
    output logic [63:0]                           wrb1_data_o
);

    localparam int EW = REG_SIZE_WIDTH + 64;

    logic [NUM_WRB_SRC-1:0] push;
    logic [NUM_WRB_SRC-1:0] pop;
    logic [NUM_WRB_SRC-1:0] full;
    logic [NUM_WRB_SRC-1:0] empty;
    logic [EW-1:0]          head [NUM_WRB_SRC];

    logic [SRC_IDX_W-1:0]   rr_ptr;
    logic                   g0_valid;
    logic                   g1_valid;
    logic [SRC_IDX_W-1:0]   g0_idx;
    logic [SRC_IDX_W-1:0]   g1_idx;
    logic [SRC_IDX_W-1:0]   scan_idx;
    logic [SRC_IDX_W-1:0]   last_idx;

    // ---------------- source FIFOs ----------------
    for (genvar i = 0; i < NUM_WRB_SRC; i++) begin : g_src
        logic [REG_SIZE_WIDTH-1:0] src_addr;
        logic                      accept;

        assign src_addr       = src_address_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
        assign src_ready_o[i] = !rst && !full[i];
        assign accept         = src_valid_i[i] && src_ready_o[i];

`ifdef WRB_ZERO_FILTER_EN
        // preg 0 is the hardwired zero register: consume the beat, store nothing.
        assign push[i] = accept && (src_addr != '0);
`else
        assign push[i] = accept;
`endif

        always_comb begin
            if (push[i]) begin
                assert (int'(src_addr) < REG_SIZE);
            end
        end

        wrb_src_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[i]),
            .pop     (pop[i]),
            .wr_data ({src_addr, src_data_i[i*64 +: 64]}),
            .rd_data (head[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    // ---------------- round-robin grant ----------------
    // Scan rr_ptr, rr_ptr+1, .. (mod 4); first two non-empty FIFOs win.
    always_comb begin
        g0_valid = 1'b0;
        g1_valid = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_WRB_SRC; k++) begin
            scan_idx = rr_ptr + SRC_IDX_W'(k);
            if (!empty[scan_idx]) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_idx   = scan_idx;
                end else if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (g0_valid) pop[g0_idx] = 1'b1;
        if (g1_valid) pop[g1_idx] = 1'b1;
    end

    // Next scan starts just past the last source served.
    assign last_idx = g1_valid ? g1_idx : g0_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (g0_valid) begin
            rr_ptr <= last_idx + 1'b1;
        end
    end

    // ---------------- registered write ports ----------------
    // Address/data hold their last value while the port is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrb0_valid_o   <= 1'b0;
            wrb0_address_o <= '0;
            wrb0_data_o    <= '0;
            wrb1_valid_o   <= 1'b0;
            wrb1_address_o <= '0;
            wrb1_data_o    <= '0;
        end else begin
            wrb0_valid_o <= g0_valid;
            wrb1_valid_o <= g1_valid;
            if (g0_valid) begin
                {wrb0_address_o, wrb0_data_o} <= head[g0_idx];
            end
            if (g1_valid) begin
                {wrb1_address_o, wrb1_data_o} <= head[g1_idx];
            end
        end
    end

endmodule

// File: tb/tb_wrb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrb_port_arbiter
//   Directed self-checking bench for wrb_port_arbiter. Inputs change and
//   outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wrb_port_arbiter;
    import rcu_wrb_pkg::*;

    localparam int AW = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]     src_valid;
    logic [3:0]     src_ready;
    logic [AW-1:0]  a [4];
    logic [63:0]    d [4];
    logic [4*AW-1:0] src_address;
    logic [4*64-1:0] src_data;
    logic           wrb0_valid, wrb1_valid;
    logic [AW-1:0]  wrb0_address, wrb1_address;
    logic [63:0]    wrb0_data, wrb1_data;

    assign src_address = {a[3], a[2], a[1], a[0]};
    assign src_data    = {d[3], d[2], d[1], d[0]};

    wrb_port_arbiter #(
        .REG_SIZE       (48),
        .REG_SIZE_WIDTH (AW),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready),
        .src_address_i  (src_address),
        .src_data_i     (src_data),
        .wrb0_valid_o   (wrb0_valid),
        .wrb0_address_o (wrb0_address),
        .wrb0_data_o    (wrb0_data),
        .wrb1_valid_o   (wrb1_valid),
        .wrb1_address_o (wrb1_address),
        .wrb1_data_o    (wrb1_data)
    );

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;
    logic [69:0] exp_q [4][$];

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Match one port's beat against the head of its source's expected queue.
    // The source index travels in data[57:56].
    task automatic sb_port(input string tag, input logic v, input logic [AW-1:0] ad,
                           input logic [63:0] dt, input logic [3:0] mask_in,
                           output logic [3:0] mask_out);
        int s;
        mask_out = mask_in;
        if (v) begin
            s = int'(dt[57:56]);
            mask_out[s] = 1'b1;
            if (exp_q[s].size() > 0) begin
                check(tag, {ad, dt}, exp_q[s].pop_front());
            end else begin
                compared++;
                mismatched++;
                $error("FAIL %s: observed=unexpected beat %0h expected=none", tag, {ad, dt});
            end
        end
    endtask

    task automatic idle_src();
        src_valid = '0;
        for (int s = 0; s < 4; s++) begin
            a[s] = '0;
            d[s] = '0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          seq [4];
        logic [3:0]  acc, acc_prev, mask, prev_mask, inv_mask;
        int          stalls;

        rst = 1'b1;
        idle_src();

        // 1. reset held for 5 cycles
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_v0",    70'(wrb0_valid), 70'(1'b0));
            check("rst_v1",    70'(wrb1_valid), 70'(1'b0));
            check("rst_ready", 70'(src_ready),  70'(4'b0000));
        end
        check("rst_a0", 70'(wrb0_address), 70'(0));
        check("rst_d1", 70'(wrb1_data),    70'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", 70'(src_ready), 70'(4'b1111));

        // 3. all four sources at once, rr_ptr=0
        src_valid = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            a[s] = AW'(s + 1);
            d[s] = 64'h100 + 64'(s);
        end
        @(negedge clk);
        idle_src();
        check("t3_idle_v0", 70'(wrb0_valid), 70'(1'b0));
        @(negedge clk);
        check("t3_c1_v",  70'({wrb0_valid, wrb1_valid}), 70'(2'b11));
        check("t3_c1_p0", {wrb0_address, wrb0_data}, {6'd1, 64'h100});
        check("t3_c1_p1", {wrb1_address, wrb1_data}, {6'd2, 64'h101});
        @(negedge clk);
        check("t3_c2_v",  70'({wrb0_valid, wrb1_valid}), 70'(2'b11));
        check("t3_c2_p0", {wrb0_address, wrb0_data}, {6'd3, 64'h102});
        check("t3_c2_p1", {wrb1_address, wrb1_data}, {6'd4, 64'h103});
        @(negedge clk);
        check("t3_c3_v", 70'({wrb0_valid, wrb1_valid}), 70'(2'b00));

        // 3b. rr_ptr back at 0: alu1 must beat md for port 0
        src_valid = 4'b1001;
        a[0] = 6'd7; d[0] = 64'h700;
        a[3] = 6'd8; d[3] = 64'h800;
        @(negedge clk);
        idle_src();
        @(negedge clk);
        check("t3b_p0", {wrb0_address, wrb0_data}, {6'd7, 64'h700});
        check("t3b_p1", {wrb1_address, wrb1_data}, {6'd8, 64'h800});
        check("t3b_v",  70'({wrb0_valid, wrb1_valid}), 70'(2'b11));
        @(negedge clk);
        check("t3b_idle", 70'({wrb0_valid, wrb1_valid}), 70'(2'b00));

        // 2. single alu1 beat, 2-cycle latency, one cycle of valid
        src_valid = 4'b0001;
        a[0] = 6'd5; d[0] = 64'h1234;
        @(negedge clk);
        idle_src();
        check("t2_lat1_v0", 70'(wrb0_valid), 70'(1'b0));
        @(negedge clk);
        check("t2_v0",   70'(wrb0_valid), 70'(1'b1));
        check("t2_p0",   {wrb0_address, wrb0_data}, {6'd5, 64'h1234});
        check("t2_v1",   70'(wrb1_valid), 70'(1'b0));
        @(negedge clk);
        check("t2_once", 70'(wrb0_valid), 70'(1'b0));
        check("t2_hold", {wrb0_address, wrb0_data}, {6'd5, 64'h1234});

        // 5. lsu beat to preg 0
        src_valid = 4'b0100;
        a[2] = 6'd0; d[2] = 64'hDEAD;
        check("t5_ready_pre", 70'(src_ready[2]), 70'(1'b1));
        @(negedge clk);
        idle_src();
        check("t5_ready_post", 70'(src_ready), 70'(4'b1111));
        @(negedge clk);
`ifdef WRB_ZERO_FILTER_EN
        check("t5_filt_v", 70'({wrb0_valid, wrb1_valid}), 70'(2'b00));
`else
        check("t5_v0", 70'(wrb0_valid), 70'(1'b1));
        check("t5_p0", {wrb0_address, wrb0_data}, {6'd0, 64'hDEAD});
        check("t5_v1", 70'(wrb1_valid), 70'(1'b0));
`endif
        @(negedge clk);
        check("t5_after", 70'({wrb0_valid, wrb1_valid}), 70'(2'b00));

        // 4. all sources streaming for 20 cycles
        for (int s = 0; s < 4; s++) seq[s] = 0;
        acc_prev  = '0;
        prev_mask = '0;
        stalls    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mask = '0;
            sb_port("t4_p0", wrb0_valid, wrb0_address, wrb0_data, mask, mask);
            sb_port("t4_p1", wrb1_valid, wrb1_address, wrb1_data, mask, mask);
            if (c >= 2) check("t4_two_writes", 70'({wrb0_valid, wrb1_valid}), 70'(2'b11));
            if (c >= 3) begin
                inv_mask = ~prev_mask;
                check("t4_alternate", 70'(mask), 70'(inv_mask));
            end
            prev_mask = mask;
            for (int s = 0; s < 4; s++) if (acc_prev[s]) seq[s]++;
            src_valid = 4'b1111;
            for (int s = 0; s < 4; s++) begin
                a[s] = AW'(16 + s);
                d[s] = {8'(s), 56'(seq[s])};
            end
            acc = src_valid & src_ready;
            for (int s = 0; s < 4; s++) begin
                if (acc[s]) exp_q[s].push_back({a[s], d[s]});
                else        stalls++;
            end
            acc_prev = acc;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mask = '0;
            sb_port("t4_drain_p0", wrb0_valid, wrb0_address, wrb0_data, mask, mask);
            sb_port("t4_drain_p1", wrb1_valid, wrb1_address, wrb1_data, mask, mask);
            idle_src();
        end
        for (int s = 0; s < 4; s++) check("t4_q_empty", 70'(exp_q[s].size()), 70'(0));
        check("t4_stalls_seen", 70'(stalls > 0), 70'(1'b1));

        // 6. reset while alu2 / md hold buffered entries
        src_valid = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            a[s] = AW'(32 + s);
            d[s] = 64'hBAD0 + 64'(s);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_src();
        @(negedge clk);
        check("t6_rst_v",     70'({wrb0_valid, wrb1_valid}), 70'(2'b00));
        check("t6_rst_ready", 70'(src_ready), 70'(4'b0000));
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t6_no_stale", 70'({wrb0_valid, wrb1_valid}), 70'(2'b00));
        end
        check("t6_ready", 70'(src_ready), 70'(4'b1111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
